lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
- Load/store unit that sits directly upstream of the byte-addressed data memory (clk, WE, ADDR, WD, RD ports).
- Takes one RV32I load/store request at a time from the execute stage using a valid/ready handshake.
- Sequences the memory access. Memory reads are combinational and every write commits all 4 bytes, so SB/SH use a read-modify-write.
- Returns sign- or zero-extended load data, or a store-done pulse, on a single-cycle response.

Parameters:
ADDR_WIDTH, 32, byte-address width; matches the memory ADDR width.
DATA_WIDTH, 32, data width; fixed at 32 (4 bytes). Other values are unsupported.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request (IDLE only).
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
req_addr  in  ADDR_WIDTH  byte address (already computed as rs1+imm).
req_wdata  in  DATA_WIDTH  store data (rs2).
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
MEM_WE  out  1  memory write enable.
MEM_ADDR  out  ADDR_WIDTH  memory byte address.
MEM_WD  out  DATA_WIDTH  memory write data; byte k goes to address MEM_ADDR+k.
MEM_RD  in  DATA_WIDTH  combinational memory read data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, addr_q=0, data_q=0, funct3_q=0, we_q=0, resp_valid=0, resp_rdata=0, resp_err=0.
- FSM states: IDLE, READ, WRITE, RESP.
- Accept: req_valid & req_ready at a posedge. Latches addr, wdata, funct3 and we.
- req_ready=1 only in IDLE, including while rst is high. No request is accepted in any other state. There is no response backpressure.
- Transitions from IDLE on accept:
  - Error request -> RESP with err.
  - Load -> READ.
  - SW -> WRITE.
  - SB/SH -> READ.
- Transitions from READ:
  - Load: capture the extended MEM_RD into data_q, then -> RESP.
  - SB/SH: capture the raw MEM_RD into data_q, then -> WRITE.
- WRITE:
  - MEM_WE=1 for exactly this one cycle.
  - MEM_WD: SW = wdata. SB = {data_q[31:8], wdata[7:0]}. SH = {data_q[31:16], wdata[15:0]}.
  - Next state: RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- MEM_ADDR=addr_q in all states. No address alignment or lane shifting is done; byte 0 of the word is the addressed byte.
- MEM_WE = (state==WRITE) & ~rst. If rst is asserted during the WRITE cycle, no write is committed.
- Load extension:
  - LB = sign-extend MEM_RD[7:0].
  - LBU = zero-extend MEM_RD[7:0].
  - LH = sign-extend MEM_RD[15:0].
  - LHU = zero-extend MEM_RD[15:0].
  - LW = MEM_RD.
- Illegal funct3 (load 3/6/7, store 3-7): resp_err=1, no memory access, MEM_WE stays 0.
- Reset mid-operation: any state -> IDLE at the next edge. The pending response is dropped and no resp_valid is issued.
- Address wrap: MEM_ADDR passes through unmodified. Wrap-around of addr+k is the memory's responsibility.

Optional Feature:
LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, is treated as an error. It goes IDLE->RESP with resp_err=1, resp_rdata=0 and no memory access.
- Undefined: no alignment check. Misaligned accesses proceed normally, since the memory is byte-addressed. resp_err is asserted only for illegal funct3.

Test Plan:
- Mem[0x10..0x13]=0x80,0x7F,0x00,0xFF. LB 0x10 -> resp 2 cycles after accept, rdata=0xFFFFFF80, err=0. LBU 0x10 -> rdata=0x00000080.
- Same data: LH 0x10 -> rdata=0x00007F80. LW 0x10 -> rdata=0xFF007F80.
- Mem word at 0x20 = 0x11223344. SB 0x20 wdata=0xAABBCCDD -> READ, WRITE, RESP; MEM_WE high exactly 1 cycle. LW 0x20 then returns 0x112233DD.
- SW 0x30 wdata=0xDEADBEEF -> resp 2 cycles after accept. LW 0x30 returns 0xDEADBEEF. req_ready=0 from the accept edge until the cycle after resp_valid.
- With LSU_MISALIGN_TRAP_EN: SW 0x31 -> resp_err=1 one cycle after accept, MEM_WE never high, mem unchanged. Without the macro: same access writes bytes 0x31-0x34. Load funct3=3 -> resp_err=1 in both builds.
- Start SH 0x40, assert rst during the WRITE cycle -> MEM_WE=0, no resp_valid, mem unchanged, state IDLE, req_ready=1 after the reset edge.

Source files
------------

// File: rtl/lsu_unit.sv
// lsu_unit: RV32I load/store sequencer in front of a byte-addressed, combinationally-read data memory.
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : execute-stage request (valid/ready); we=1 store, funct3 selects width/extension
//   resp_*            : one-cycle response pulse with extended load data or error flag
//   MEM_*             : memory port; every write commits all 4 bytes, so SB/SH read-modify-write
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned LH/LHU/SH/LW/SW are returned as errors
module lsu_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WD,
    input  logic [DATA_WIDTH-1:0] MEM_RD
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data, r_wdata, w_ext;
    logic [2:0]            r_funct3;
    logic                  r_we, r_err;
    logic                  w_accept, w_illegal, w_misalign, w_err;
    assign w_accept = req_valid & req_ready;
    // legal loads: 0,1,2,4,5; legal stores: 0,1,2
    assign w_illegal = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_err = w_illegal | w_misalign;
    always_comb begin
        w_ext = r_funct3 == 3'd0 ? {{24{MEM_RD[7]}}, MEM_RD[7:0]} :
                r_funct3 == 3'd4 ? {24'd0, MEM_RD[7:0]} :
                r_funct3 == 3'd1 ? {{16{MEM_RD[15]}}, MEM_RD[15:0]} :
                r_funct3 == 3'd5 ? {16'd0, MEM_RD[15:0]} : MEM_RD;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_err ? RESP : (req_we && req_funct3 == 3'd2) ? WRITE : READ;
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                r_err    <= w_err;
                r_data   <= '0;
            end
            // stores keep the raw word for merging; loads keep the extended value
            if (r_state == READ) r_data <= r_we ? MEM_RD : w_ext;
        end
    end
    assign req_ready  = r_state == IDLE;
    assign resp_valid = r_state == RESP;
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = (resp_valid && !r_we && !r_err) ? r_data : '0;
    assign MEM_WE     = (r_state == WRITE) & ~rst;
    assign MEM_ADDR   = r_addr;
    assign MEM_WD     = r_funct3 == 3'd0 ? {r_data[31:8], r_wdata[7:0]} :
                        r_funct3 == 3'd1 ? {r_data[31:16], r_wdata[15:0]} : r_wdata;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: scoreboard bench for lsu_unit with a byte memory and a shadow reference memory.
module tb_lsu_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, MEM_WE;
    logic [31:0] resp_rdata, MEM_ADDR, MEM_WD, MEM_RD;
    logic [7:0]  mem [0:255];
    logic [7:0]  shadow [0:255];
    int          n_chk = 0, n_fail = 0, we_cnt = 0;
    typedef struct { logic err; logic [31:0] rdata; int lat; int wes; } exp_t;
    exp_t        sb [$];

    lsu_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 clk = ~clk;

    assign MEM_RD = {mem[MEM_ADDR[7:0] + 8'd3], mem[MEM_ADDR[7:0] + 8'd2], mem[MEM_ADDR[7:0] + 8'd1], mem[MEM_ADDR[7:0]]};

    always @(posedge clk)
        if (MEM_WE)
            for (int k = 0; k < 4; k++) mem[MEM_ADDR[7:0] + 8'(k)] <= MEM_WD[8*k +: 8];

    always @(negedge clk) we_cnt += int'(MEM_WE);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    function automatic logic [31:0] sh_word(input logic [7:0] a);
        return {shadow[a + 8'd3], shadow[a + 8'd2], shadow[a + 8'd1], shadow[a]};
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        e = we ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] a);
        logic [31:0] w;
        w = sh_word(a);
        if (f3 == 3'd0) return {{24{w[7]}}, w[7:0]};
        if (f3 == 3'd4) return {24'd0, w[7:0]};
        if (f3 == 3'd1) return {{16{w[15]}}, w[15:0]};
        if (f3 == 3'd5) return {16'd0, w[15:0]};
        return w;
    endfunction

    task automatic access(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t e, got;
        int   n, busy_ready, we0;
        e.err   = ref_err(we, f3, a);
        e.rdata = (we || e.err) ? 32'd0 : ref_load(f3, a[7:0]);
        e.lat   = e.err ? 1 : (we && f3 != 3'd2) ? 3 : 2;
        e.wes   = (we && !e.err) ? 1 : 0;
        if (we && !e.err)
            for (int k = 0; k < (f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4); k++) shadow[a[7:0] + 8'(k)] = wd[8*k +: 8];
        @(negedge clk);
        check({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        we0 = we_cnt;
        @(posedge clk);
        sb.push_back(e);
        #1 req_valid = 1'b0;
        n = 0; busy_ready = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            busy_ready += int'(req_ready);
            if (resp_valid) break;
        end
        check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".busy_ready"}, busy_ready, 0);
        if (resp_valid && sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, ".lat"}, n, got.lat);
            check({tag, ".err"}, {31'd0, resp_err}, {31'd0, got.err});
            check({tag, ".rdata"}, resp_rdata, got.rdata);
            @(negedge clk);
            check({tag, ".we_pulses"}, we_cnt - we0, got.wes);
            check({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
            if (we) check({tag, ".mem"}, mem_word(a[7:0]), sh_word(a[7:0]));
        end
    endtask

    initial begin
        int rv, we0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hFF007F80;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h11223344;
        {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} = 32'hCAFEF00D;
        for (int i = 0; i < 256; i++) shadow[i] = mem[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        check("rst.mem_we", {31'd0, MEM_WE}, 32'd0);
        check("rst.mem_addr", MEM_ADDR, 32'd0);
        rst = 1'b0;
        check("model.lb", ref_load(3'd0, 8'h10), 32'hFFFFFF80);
        access("lb", 1'b0, 3'd0, 32'h10, 32'd0);
        access("lbu", 1'b0, 3'd4, 32'h10, 32'd0);
        access("lh", 1'b0, 3'd1, 32'h10, 32'd0);
        access("lhu_12", 1'b0, 3'd5, 32'h12, 32'd0);
        access("lh_12", 1'b0, 3'd1, 32'h12, 32'd0);
        access("lw", 1'b0, 3'd2, 32'h10, 32'd0);
        access("lb_11", 1'b0, 3'd0, 32'h11, 32'd0);
        access("sb", 1'b1, 3'd0, 32'h20, 32'hAABBCCDD);
        access("lw_20", 1'b0, 3'd2, 32'h20, 32'd0);
        check("model.sb", sh_word(8'h20), 32'h112233DD);
        access("sh", 1'b1, 3'd1, 32'h20, 32'h12345678);
        access("lw_20b", 1'b0, 3'd2, 32'h20, 32'd0);
        access("sw", 1'b1, 3'd2, 32'h30, 32'hDEADBEEF);
        access("lw_30", 1'b0, 3'd2, 32'h30, 32'd0);
        access("sw_31", 1'b1, 3'd2, 32'h31, 32'h01020304);
        access("lw_30b", 1'b0, 3'd2, 32'h30, 32'd0);
        access("lw_34", 1'b0, 3'd2, 32'h34, 32'd0);
        access("lh_odd", 1'b0, 3'd1, 32'h11, 32'd0);
        access("ld_f3", 1'b0, 3'd3, 32'h10, 32'd0);
        access("ld_f7", 1'b0, 3'd7, 32'h10, 32'd0);
        access("st_f5", 1'b1, 3'd5, 32'h50, 32'h55555555);
        access("lw_50", 1'b0, 3'd2, 32'h50, 32'd0);
        // SH interrupted by reset in its WRITE cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h40; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstw.we_before", {31'd0, MEM_WE}, 32'd1);
        we0 = we_cnt;
        rst = 1'b1;
        #1 check("rstw.we_gated", {31'd0, MEM_WE}, 32'd0);
        @(posedge clk);
        #1 check("rstw.ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rv = 0;
        repeat (4) begin @(negedge clk); rv += int'(resp_valid); end
        check("rstw.no_resp", rv, 0);
        check("rstw.no_write", we_cnt - we0, 0);
        check("rstw.mem", mem_word(8'h40), sh_word(8'h40));
        access("lw_40", 1'b0, 3'd2, 32'h40, 32'd0);
        check("sb.empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
